// File: rtl/smi_header_extract_pf2.sv
// smi_header_extract_pf2: strips a 1..2 flit header from each SMI frame and realigns the payload.
// Optional runt discard and counter: define SMI_HDR_EXTRACT_RUNT_DROP_EN.
module smiSelfLinkBufferFifoS #(
  parameter int Width = 72,
  parameter int Depth = 16,
  parameter int IndexSize = 4
) (
  input  logic             clk,
  input  logic             srstn,
  input  logic             inReady,
  input  logic [Width-1:0] inData,
  output logic             inStop,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);
  logic [Width-1:0] mem_q [Depth];
  logic [IndexSize-1:0] wr_q, rd_q;
  logic [IndexSize:0] cnt_q;
  logic wr, rd;
  assign inStop = cnt_q == (IndexSize+1)'(Depth);
  assign outReady = cnt_q != '0;
  assign outData = mem_q[rd_q];
  assign wr = inReady & ~inStop;
  assign rd = outReady & ~outStop;
  always_ff @(posedge clk) begin
    if (!srstn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q == IndexSize'(Depth-1) ? '0 : wr_q + 1'b1;
      if (rd) rd_q <= rd_q == IndexSize'(Depth-1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (IndexSize+1)'(wr) - (IndexSize+1)'(rd);
    end
  end
  always_ff @(posedge clk) if (wr) mem_q[wr_q] <= inData;
endmodule

module smi_header_extract_pf2 #(
  parameter int FlitWidth = 8,
  parameter int HeadWidth = 14,
  parameter int FifoSize = 16
) (
  input  logic                   clk,
  input  logic                   srstn,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   headerReady,
  output logic [HeadWidth*8-1:0] headerData,
  output logic                   headerEmpty,
  input  logic                   headerStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
  output logic [15:0]            runtCount,
`endif
  input  logic                   smiOutStop
);
  localparam int FifoIndexSize = $clog2(FifoSize);
  localparam int Head2Width = HeadWidth - FlitWidth;
  localparam int FlitSplit = FlitWidth - Head2Width;
  localparam int DW = FlitWidth * 8;
  localparam int HW = HeadWidth * 8;
  localparam int H2B = Head2Width * 8;
  localparam int FSB = FlitSplit * 8;
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
  localparam bit Drop = 1'b1;
`else
  localparam bit Drop = 1'b0;
`endif
  typedef enum logic [1:0] {Idle, Head2, Copy, Tail} state_t;
  state_t state_q;
  logic in_ready_q, hdr_ready_q, hdr_empty_q;
  logic [7:0] in_eofc_q, tail_eofc_q, e;
  logic [DW-1:0] in_data_q, lo_q, lo_mask;
  logic [FSB-1:0] carry_q;
  logic [HW-1:0] hdr_data_q;
  logic [H2B-1:0] hi_mask;
  logic hdr_free, hdr_runt, fifo_stop, halt, take, fifo_wr;
  logic [DW+7:0] fifo_wdata, fifo_rdata;
  assign e = in_eofc_q;
  assign hdr_free = ~hdr_ready_q | ~headerStop;
  assign hdr_runt = e != 8'd0 && e < 8'(Head2Width);
  assign halt = state_q == Idle  ? (!Drop && e != 8'd0 && !hdr_free) :
                state_q == Head2 ? (!hdr_free || fifo_stop) :
                state_q == Copy  ? fifo_stop : 1'b1;
  assign take = in_ready_q & ~halt;
  assign smiInStop = in_ready_q & halt;
  assign fifo_wr = state_q == Head2 ? take && e > 8'(Head2Width) :
                   state_q == Copy  ? take : state_q == Tail && !fifo_stop;
  assign fifo_wdata[DW+7:DW] = state_q == Head2 ? e - 8'(Head2Width) :
                               state_q == Copy  ? (e == 8'd0 || e > 8'(Head2Width) ? 8'd0 : e + 8'(FlitSplit)) :
                               tail_eofc_q;
  assign fifo_wdata[DW-1:0] = state_q == Head2 ? DW'(in_data_q[DW-1 -: FSB]) :
                              state_q == Copy  ? {in_data_q[H2B-1:0], carry_q} : DW'(carry_q);
  // Runt headers keep only the bytes that actually arrived.
  always_comb begin
    lo_mask = '0;
    hi_mask = '0;
    for (int b = 0; b < FlitWidth; b++) lo_mask[b*8 +: 8] = {8{8'(b) < e}};
    for (int b = 0; b < Head2Width; b++) hi_mask[b*8 +: 8] = {8{!hdr_runt || 8'(b) < e}};
  end
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= Idle;
      in_ready_q <= 1'b0;
      hdr_ready_q <= 1'b0;
      hdr_empty_q <= 1'b0;
    end else begin
      if (!smiInStop) in_ready_q <= smiInReady;
      if (hdr_ready_q && !headerStop) hdr_ready_q <= 1'b0;
      case (state_q)
        Idle: if (take) begin
          if (e == 8'd0) state_q <= Head2;
          else if (!Drop) begin
            hdr_ready_q <= 1'b1;
            hdr_empty_q <= 1'b1;
          end
        end
        Head2: if (take) begin
          state_q <= e == 8'd0 ? Copy : Idle;
          if (!(Drop && hdr_runt)) begin
            hdr_ready_q <= 1'b1;
            hdr_empty_q <= e != 8'd0 && e <= 8'(Head2Width);
          end
        end
        Copy: if (take) state_q <= e == 8'd0 ? Copy : e <= 8'(Head2Width) ? Idle : Tail;
        default: if (!fifo_stop) state_q <= Idle;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!smiInStop) begin
      in_eofc_q <= smiInEofc & 8'(2*FlitWidth-1);
      in_data_q <= smiInData;
    end
    if (take && state_q == Idle) lo_q <= in_data_q;
    if (take && state_q == Idle && e != 8'd0 && !Drop) hdr_data_q <= HW'(in_data_q & lo_mask);
    if (take && state_q == Head2 && !(Drop && hdr_runt)) hdr_data_q <= {in_data_q[H2B-1:0] & hi_mask, lo_q};
    if (take && (state_q == Head2 || state_q == Copy)) carry_q <= in_data_q[DW-1 -: FSB];
    if (take && state_q == Copy) tail_eofc_q <= e - 8'(Head2Width);
  end
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
  logic [15:0] runt_cnt_q;
  always_ff @(posedge clk) begin
    if (!srstn) runt_cnt_q <= '0;
    else if (take && ((state_q == Idle && e != 8'd0) || (state_q == Head2 && hdr_runt)) && runt_cnt_q != 16'hffff)
      runt_cnt_q <= runt_cnt_q + 16'd1;
  end
  assign runtCount = runt_cnt_q;
`endif
  assign headerReady = hdr_ready_q;
  assign headerData = hdr_data_q;
  assign headerEmpty = hdr_empty_q;
  assign smiOutEofc = fifo_rdata[DW+7:DW];
  assign smiOutData = fifo_rdata[DW-1:0];
  smiSelfLinkBufferFifoS #(.Width(DW+8), .Depth(FifoSize), .IndexSize(FifoIndexSize)) u_fifo (
    .clk(clk),
    .srstn(srstn),
    .inReady(fifo_wr),
    .inData(fifo_wdata),
    .inStop(fifo_stop),
    .outReady(smiOutReady),
    .outData(fifo_rdata),
    .outStop(smiOutStop)
  );
endmodule

// File: tb/tb_smi_header_extract_pf2.sv
// tb_smi_header_extract_pf2: vector table plus byte-stream scoreboard for the SMI header extractor.
module tb_smi_header_extract_pf2;
  localparam int FW = 8;
  localparam int HW = 14;
  logic clk = 1'b0, srstn = 1'b0;
  logic smiInReady = 1'b0, smiInStop, headerReady, headerEmpty, headerStop = 1'b0;
  logic smiOutReady, smiOutStop = 1'b0;
  logic [7:0] smiInEofc = '0, smiOutEofc;
  logic [FW*8-1:0] smiInData = '0, smiOutData;
  logic [HW*8-1:0] headerData;
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
  logic [15:0] runtCount;
`endif
  typedef struct { logic [7:0] eofc; logic [FW*8-1:0] data; } pay_t;
  typedef struct { logic [HW*8-1:0] data; logic empty; } hdr_t;
  typedef struct { int len; int flits; logic [7:0] last; logic empty; int hdrs; } vec_t;
  pay_t pay_q[$];
  hdr_t hdr_q[$];
  vec_t vt[10];
  int total = 0, bad = 0, hdr_cnt = 0, pay_cnt = 0, runt_exp = 0;
  logic [7:0] last_eofc = '0;
  logic last_empty = 1'b0, prev_hold = 1'b0, stall_en = 1'b0;
  logic [HW*8-1:0] prev_hd;
  hdr_t mh;
  pay_t mp;
  logic [FW*8-1:0] msk;

  smi_header_extract_pf2 dut (
    .clk(clk), .srstn(srstn),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
    .headerReady(headerReady), .headerData(headerData), .headerEmpty(headerEmpty), .headerStop(headerStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData),
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    .runtCount(runtCount),
`endif
    .smiOutStop(smiOutStop)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial forever begin
    @(posedge clk);
    #1;
    smiOutStop = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    headerStop = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input int len, input logic [7:0] fb[64]);
    hdr_t h;
    pay_t p;
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    if (len < HW) begin
      runt_exp++;
      return;
    end
`endif
    h.data = '0;
    for (int i = 0; i < HW; i++) if (i < len) h.data[i*8 +: 8] = fb[i];
    h.empty = len <= HW;
    hdr_q.push_back(h);
    for (int off = HW; off < len; off += FW) begin
      p.data = '0;
      for (int b = 0; b < FW; b++) if (off + b < len) p.data[b*8 +: 8] = fb[off+b];
      p.eofc = (len - off <= FW) ? 8'(len - off) : 8'd0;
      pay_q.push_back(p);
    end
  endtask

  task automatic send_flit(input logic [FW*8-1:0] d, input logic [7:0] e);
    logic acc = 1'b0;
    int to = 0;
    smiInReady = 1'b1;
    smiInData = d;
    smiInEofc = e;
    while (!acc && to < 500) begin
      @(negedge clk);
      acc = !smiInStop;
      @(posedge clk);
      #1;
      to++;
    end
    check("in_accept", 128'(acc), 128'(1));
    smiInReady = 1'b0;
  endtask

  task automatic send_frame(input int len);
    logic [7:0] fb[64];
    logic [FW*8-1:0] d;
    int n;
    for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    model(len, fb);
    n = (len + FW - 1) / FW;
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < FW; b++) d[b*8 +: 8] = fb[f*FW+b];
      send_flit(d, f == n - 1 ? 8'(len - f*FW) : 8'd0);
    end
  endtask

  task automatic drain();
    int to = 0;
    while ((pay_q.size() != 0 || hdr_q.size() != 0) && to < 3000) begin
      @(posedge clk);
      to++;
    end
    check("drain_left", 128'(pay_q.size() + hdr_q.size()), 128'(0));
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!srstn) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        check("hdr_hold_ready", 128'(headerReady), 128'(1));
        check("hdr_hold_data", 128'(headerData), 128'(prev_hd));
      end
      if (headerReady && !headerStop) begin
        hdr_cnt++;
        last_empty = headerEmpty;
        total++;
        if (hdr_q.size() == 0) begin
          bad++;
          $display("FAIL hdr_extra: got %0h expected none", headerData);
        end else begin
          mh = hdr_q.pop_front();
          check("hdr_data", 128'(headerData), 128'(mh.data));
          check("hdr_empty", 128'(headerEmpty), 128'(mh.empty));
        end
      end
      prev_hold = headerReady && headerStop;
      prev_hd = headerData;
      if (smiOutReady && !smiOutStop) begin
        pay_cnt++;
        last_eofc = smiOutEofc;
        total++;
        if (pay_q.size() == 0) begin
          bad++;
          $display("FAIL pay_extra: got %0h expected none", smiOutData);
        end else begin
          mp = pay_q.pop_front();
          for (int b = 0; b < FW; b++) msk[b*8 +: 8] = {8{mp.eofc == 8'd0 || 8'(b) < mp.eofc}};
          check("pay_eofc", 128'(smiOutEofc), 128'(mp.eofc));
          check("pay_data", 128'(smiOutData & msk), 128'(mp.data & msk));
        end
      end
    end
  end

  initial begin
    vt[0] = '{32, 3, 8'd2, 1'b0, 1};
    vt[1] = '{20, 1, 8'd6, 1'b0, 1};
    vt[2] = '{31, 3, 8'd1, 1'b0, 1};
    vt[3] = '{14, 0, 8'd0, 1'b1, 1};
    vt[4] = '{15, 1, 8'd1, 1'b0, 1};
    vt[5] = '{16, 1, 8'd2, 1'b0, 1};
    vt[6] = '{22, 1, 8'd8, 1'b0, 1};
    vt[7] = '{64, 7, 8'd2, 1'b0, 1};
    vt[8] = '{6, 0, 8'd0, 1'b1, 1};
    vt[9] = '{11, 0, 8'd0, 1'b1, 1};
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    vt[8].hdrs = 0;
    vt[9].hdrs = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_ready", 128'(smiOutReady), 128'(0));
    check("rst_hdr_ready", 128'(headerReady), 128'(0));
    check("rst_hdr_empty", 128'(headerEmpty), 128'(0));
    check("rst_in_stop", 128'(smiInStop), 128'(0));
    srstn = 1'b1;
    @(posedge clk);
    #1;
    foreach (vt[k]) begin
      hdr_cnt = 0;
      pay_cnt = 0;
      last_eofc = '0;
      last_empty = 1'b0;
      send_frame(vt[k].len);
      drain();
      check($sformatf("vec%0d_hdrs", k), 128'(hdr_cnt), 128'(vt[k].hdrs));
      check($sformatf("vec%0d_flits", k), 128'(pay_cnt), 128'(vt[k].flits));
      if (vt[k].flits > 0) check($sformatf("vec%0d_last_eofc", k), 128'(last_eofc), 128'(vt[k].last));
      if (vt[k].hdrs > 0) check($sformatf("vec%0d_empty", k), 128'(last_empty), 128'(vt[k].empty));
    end
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    check("runt_count", 128'(runtCount), 128'(runt_exp));
`endif
    send_flit(64'h0706050403020100, 8'd0);
    send_flit(64'h0f0e0d0c0b0a0908, 8'd0);
    srstn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_ready", 128'(smiOutReady), 128'(0));
    check("midrst_hdr_ready", 128'(headerReady), 128'(0));
    check("midrst_hdr_empty", 128'(headerEmpty), 128'(0));
    check("midrst_in_stop", 128'(smiInStop), 128'(0));
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    check("midrst_runt_count", 128'(runtCount), 128'(0));
    runt_exp = 0;
`endif
    srstn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(32);
    drain();
    stall_en = 1'b1;
    for (int i = 0; i < 200; i++) send_frame(int'($urandom_range(1, 40)));
    drain();
    stall_en = 1'b0;
`ifdef SMI_HDR_EXTRACT_RUNT_DROP_EN
    check("runt_count_final", 128'(runtCount), 128'(runt_exp));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
